// File: rtl/ysyx_24100027_imm_pack_if.sv
// Request/response bundle for the immediate packer: master drives requests and
// consumes results, slave is the packer itself.
interface ysyx_24100027_imm_pack_if #(
  parameter int CNT_W     = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           extop;
  logic [31:0]          base;
  logic [31:0]          imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          inst;
  logic                 err;
  logic [CNT_W-1:0]     emit_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, extop, base, imm, out_ready,
    input  in_ready, out_valid, inst, err, emit_cnt, err_cnt
  );

  modport slave (
    input  in_valid, extop, base, imm, out_ready,
    output in_ready, out_valid, inst, err, emit_cnt, err_cnt
  );
endinterface

// File: rtl/ysyx_24100027_imm_pack.sv
// Immediate packer: scatters a 32-bit immediate into an RV32I I/U/S/B/J template.
// Optional macro IMM_RANGE_CHECK_EN adds representability checking and err_cnt.
module ysyx_24100027_imm_pack #(
  parameter int CNT_W     = 16,
  parameter int ERR_CNT_W = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_24100027_imm_pack_if.slave   bus
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_U = 3'b001,
    FMT_S = 3'b010,
    FMT_B = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic [31:0]      inst_q;
  logic [31:0]      inst_d;
  logic             err_q;
  logic             err_d;
  logic             illegal;
  logic             out_valid_q;
  logic [CNT_W-1:0] emit_cnt_q;
  logic             accept;
  logic             handshake;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign handshake     = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.inst      = inst_q;
  assign bus.err       = err_q;
  assign bus.emit_cnt  = emit_cnt_q;

  // Template bits pass through; only the selected format's immediate field is overwritten.
  always_comb begin
    inst_d  = bus.base;
    illegal = 1'b0;
    case (bus.extop)
      FMT_I: inst_d[31:20] = bus.imm[11:0];
      FMT_U: inst_d[31:12] = bus.imm[31:12];
      FMT_S: begin
        inst_d[31:25] = bus.imm[11:5];
        inst_d[11:7]  = bus.imm[4:0];
      end
      FMT_B: begin
        inst_d[31]    = bus.imm[12];
        inst_d[7]     = bus.imm[11];
        inst_d[30:25] = bus.imm[10:5];
        inst_d[11:8]  = bus.imm[4:1];
      end
      FMT_J: begin
        inst_d[31]    = bus.imm[20];
        inst_d[19:12] = bus.imm[19:12];
        inst_d[20]    = bus.imm[11];
        inst_d[30:21] = bus.imm[10:1];
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic                 range_bad;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // The immediate must survive truncation exactly; B/J also need an even offset.
  always_comb begin
    range_bad = 1'b0;
    case (bus.extop)
      FMT_I, FMT_S: range_bad = bus.imm[31:12] != {20{bus.imm[11]}};
      FMT_U:        range_bad = bus.imm[11:0] != 12'h000;
      FMT_B:        range_bad = bus.imm[0] || (bus.imm[31:13] != {19{bus.imm[12]}});
      FMT_J:        range_bad = bus.imm[0] || (bus.imm[31:21] != {11{bus.imm[20]}});
      default:      range_bad = 1'b0;
    endcase
  end

  assign err_d = illegal || range_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (handshake && err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign err_d       = illegal;
  assign bus.err_cnt = '0;
`endif

  // A new accept overrides the outgoing handshake so a result can be replaced in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      emit_cnt_q  <= '0;
    end else begin
      if (accept) begin
        inst_q      <= inst_d;
        err_q       <= err_d;
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
      if (handshake) begin
        emit_cnt_q <= emit_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/ysyx_24100027_imm_pack.md
Name: ysyx_24100027_imm_pack

Overview:
- Immediate packer: the encode direction of the NPC immediate extraction path.
- Takes an instruction template plus a 32-bit immediate and a format select. Scatters the immediate into the RV32I I/U/S/B/J bit positions and returns the finished 32-bit instruction.
- Used by the self-test instruction injector and the bootstrap sequencer to build instructions on the fly.
- Single registered output stage with valid/ready handshake on both sides.

Parameters:
- CNT_W, 16, width of emitted-instruction counter
- ERR_CNT_W, 8, width of saturating error counter (used only with the optional feature)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  request valid
- in_ready  output  1  request accepted this cycle when in_valid is also high
- extop  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J, 101-111 illegal
- base  input  32  template supplying opcode/rd/rs1/rs2/funct fields
- imm  input  32  immediate value, two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- inst  output  32  packed instruction
- err  output  1  result flagged as not representable / illegal format
- emit_cnt  output  CNT_W  count of completed output handshakes
- err_cnt  output  ERR_CNT_W  saturating count of errored outputs

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - out_valid=0, inst=0, err=0, emit_cnt=0, err_cnt=0.
  - Any held result is discarded.
  - in_ready=1 once reset is released.
- in_ready = !out_valid || out_ready. This gives full throughput of one instruction per cycle with back-to-back accepts.
- Accept (in_valid && in_ready):
  - Next edge loads inst, err and sets out_valid=1.
  - Latency is 1 cycle, input-to-output.
- Output hold: while out_valid && !out_ready, inst and err are stable and in_ready=0.
- Handshake: out_valid && out_ready with no accept drives out_valid=0 next edge. If an accept happens in the same cycle, the new result replaces the old and out_valid stays 1.
- Encoding: all template bits are taken from base except the immediate field bits, which are overwritten. Bits of base inside the immediate field are ignored.
  - I: inst[31:20]=imm[11:0]
  - U: inst[31:12]=imm[31:12]
  - S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12]; inst[7]=imm[11]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1]
  - J: inst[31]=imm[20]; inst[19:12]=imm[19:12]; inst[20]=imm[11]; inst[30:21]=imm[10:1]
  - Illegal extop: inst=base unchanged, err=1 (always, independent of the optional feature).
  - Immediate bits not listed for the selected format are dropped.
- emit_cnt increments by 1 on each output handshake and wraps at 2^CNT_W-1 to 0.
- A simultaneous accept and handshake counts the outgoing result only.
- in_valid may deassert without an accept; no state change results.
- base, imm and extop are sampled only on an accept.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN
- Defined:
  - err is additionally set when imm is not exactly representable in the selected format:
    - I/S: imm is not the sign-extension of imm[11:0].
    - U: imm[11:0] != 0.
    - B: imm[0]=1, or imm is not the sign-extension of imm[12:0].
    - J: imm[0]=1, or imm is not the sign-extension of imm[20:0].
  - inst is still produced by truncation.
  - err_cnt increments on each output handshake with err=1 and saturates at all-ones.
- Undefined:
  - err is set only for illegal extop.
  - err_cnt is tied to 0.
  - No range logic is instantiated.

Test Plan:
- I-format, extop=000, base=0x00000093, imm=0xFFFFFFFF, out_ready=1 -> one cycle later out_valid=1, inst=0xFFF00093, err=0, emit_cnt=1.
- U then S back-to-back, in_valid held 2 cycles:
  - extop=001, base=0x000000B7, imm=0x12345000 -> 0x123450B7.
  - Then extop=010, base=0x00112023, imm=0xFFFFFFFC -> 0xFE112E23 on consecutive cycles.
  - in_ready stays 1.
- B/J formats:
  - extop=011, base=0x00000063, imm=8 -> 0x00000463.
  - extop=100, base=0x000000EF, imm=0x800 -> 0x001000EF.
  - Both with err=0.
- Backpressure: out_ready=0 for 3 cycles after a result, with a second request pending.
  - inst and out_valid stay stable; in_ready=0.
  - On release, the second result appears the next cycle; emit_cnt advances by exactly 2 total.
- Errors:
  - extop=110 -> inst=base, err=1 (both builds).
  - With IMM_RANGE_CHECK_EN: I imm=0x800 -> err=1, inst[31:20]=0x800.
  - With IMM_RANGE_CHECK_EN: B imm=5 -> err=1.
  - With IMM_RANGE_CHECK_EN: err_cnt=3 after the three handshakes above.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Immediately out_valid=0, emit_cnt=0, err_cnt=0.
  - After release, the first new request is emitted with emit_cnt=1.
